// File: rtl/note_sequencer.sv
// note_sequencer: step-table note player feeding a variable clock divider.
// Each step lasts tempo_div+1 cycles; period_out carries the stored divisor
// (0 = rest) and gate marks the sounding part of the step.
// Build option: define SEQ_LOOP_EN to loop the pattern forever; otherwise
// playback stops after last_step and pulses done.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | not playing; outputs parked (period_out=0, gate=0)
// S_PLAY | stepping through the table, one step per tempo_div+1 cycles
module note_sequencer #(
  parameter int STEPS   = 8,
  parameter int TEMPO_W = 16,
  localparam int AW     = $clog2(STEPS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [TEMPO_W-1:0] tempo_div,
  input  logic [AW-1:0]      last_step,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [9:0]         wr_data,
  output logic [9:0]         period_out,
  output logic               gate,
  output logic [AW-1:0]      step_idx,
  output logic               step_strobe,
  output logic               busy,
  output logic               done
);

  typedef enum logic {S_IDLE, S_PLAY} state_t;

  state_t             state_q;
  logic [AW-1:0]      step_q;
  logic [TEMPO_W-1:0] cnt_q;
  logic [9:0]         period_q;
  logic               strobe_q;
  logic               done_q;
  logic               armed_q;
  logic [9:0]         table_q [STEPS];
  logic [AW-1:0]      step_inc;

  assign step_inc = step_q + 1'b1;

  // Step table: written on any wr_en cycle, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STEPS; i++) table_q[i] <= '0;
    end else if (wr_en) begin
      table_q[wr_addr] <= wr_data;
    end
  end

  // Playback FSM; period_out is only reloaded at step entry so table
  // writes to the sounding step wait for its next visit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      step_q   <= '0;
      cnt_q    <= '0;
      period_q <= '0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      // start is only honoured once an edge has passed with reset released
      armed_q  <= 1'b1;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      if (stop) begin
        if (state_q == S_PLAY) begin
          state_q  <= S_IDLE;
          step_q   <= '0;
          cnt_q    <= '0;
          period_q <= '0;
        end
      end else if (start && armed_q) begin
        state_q  <= S_PLAY;
        step_q   <= '0;
        cnt_q    <= '0;
        period_q <= table_q[0];
        strobe_q <= 1'b1;
      end else if (state_q == S_PLAY) begin
        if (cnt_q >= tempo_div) begin
          cnt_q <= '0;
          if (step_q >= last_step) begin
`ifdef SEQ_LOOP_EN
            step_q   <= '0;
            period_q <= table_q[0];
            strobe_q <= 1'b1;
`else
            state_q  <= S_IDLE;
            step_q   <= '0;
            period_q <= '0;
            done_q   <= 1'b1;
`endif
          end else begin
            step_q   <= step_inc;
            period_q <= table_q[step_inc];
            strobe_q <= 1'b1;
          end
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  // Gate drops on the final cycle of each step to articulate repeated notes;
  // with tempo_div=0 there is no room for a gap, so the note stays on.
  assign gate = (state_q == S_PLAY) && (period_q != '0) &&
                ((tempo_div == '0) || (cnt_q < tempo_div));

  assign period_out  = period_q;
  assign step_idx    = step_q;
  assign step_strobe = strobe_q;
  assign busy        = (state_q == S_PLAY);
`ifdef SEQ_LOOP_EN
  assign done        = 1'b0;
`else
  assign done        = done_q;
`endif

endmodule

// File: tb/tb_note_sequencer.sv
module tb_note_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, wr_en;
  logic [15:0] tempo_div;
  logic [2:0]  last_step, wr_addr;
  logic [9:0]  wr_data;
  logic [9:0]  period_out;
  logic        gate, step_strobe, busy, done;
  logic [2:0]  step_idx;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  // reference model state: what the player is doing in plain terms
  bit         m_play;
  int         m_step;
  int         m_elapsed;
  logic [9:0] m_period;
  bit         m_strobe, m_done, m_armed;
  logic [9:0] m_tab [8];
  logic [9:0] vals [4];

  note_sequencer #(.STEPS(8), .TEMPO_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .tempo_div(tempo_div), .last_step(last_step), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .period_out(period_out),
    .gate(gate), .step_idx(step_idx), .step_strobe(step_strobe),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_play = 0; m_step = 0; m_elapsed = 0; m_period = '0;
    m_strobe = 0; m_done = 0; m_armed = 0;
    for (int i = 0; i < 8; i++) m_tab[i] = '0;
  endtask

  // One clock of the player, from the rules: a step lasts until its elapsed
  // count reaches tempo_div; the step after last_step ends the pattern.
  task automatic model_step();
    m_strobe = 0;
    m_done   = 0;
    if (stop) begin
      if (m_play) begin
        m_play = 0; m_step = 0; m_elapsed = 0; m_period = '0;
      end
    end else if (start && m_armed) begin
      m_play = 1; m_step = 0; m_elapsed = 0; m_period = m_tab[0]; m_strobe = 1;
    end else if (m_play) begin
      if (m_elapsed >= int'(tempo_div)) begin
        m_elapsed = 0;
        if (m_step >= int'(last_step)) begin
`ifdef SEQ_LOOP_EN
          m_step = 0; m_period = m_tab[0]; m_strobe = 1;
`else
          m_play = 0; m_step = 0; m_period = '0; m_done = 1;
`endif
        end else begin
          m_step = m_step + 1; m_period = m_tab[m_step]; m_strobe = 1;
        end
      end else begin
        m_elapsed++;
      end
    end
    if (wr_en) m_tab[wr_addr] = wr_data;
    m_armed = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  // Single compare process: DUT against model on every falling edge.
  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      chk("period", period_out, m_period);
      chk("gate", gate, m_play && (m_period != 0) &&
          ((tempo_div == 0) || (m_elapsed < int'(tempo_div))));
      chk("step_idx", step_idx, m_step);
      chk("strobe", step_strobe, m_strobe);
      chk("busy", busy, m_play);
      chk("done", done, m_done);
    end
  end

  initial begin
    vals[0] = 10'd200; vals[1] = 10'd25; vals[2] = 10'd0; vals[3] = 10'd3;
    rst_n = 0; start = 0; stop = 0; wr_en = 0; wr_addr = '0; wr_data = '0;
    tempo_div = '0; last_step = '0;
    m_reset();
    chk_on = 1;
    #1;
    chk("rst_period", period_out, 0);
    chk("rst_gate", gate, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_step", step_idx, 0);
    chk("rst_strobe", step_strobe, 0);
    repeat (3) tick();

    // start on the very first edge after reset release must be ignored
    rst_n = 1; start = 1;
    tick();
    start = 0;
    chk("start_ignored_after_rst", busy, 0);

    for (int i = 0; i < 4; i++) begin
      wr_en = 1; wr_addr = 3'(i); wr_data = vals[i];
      tick();
    end
    wr_en = 0;

    // basic pattern: four steps of four cycles each
    last_step = 3; tempo_div = 3; start = 1;
    tick();
    start = 0;
`ifdef SEQ_LOOP_EN
    for (int k = 0; k < 48; k++) begin
      chk("pat_period", period_out, vals[(k/4)%4]);
      chk("pat_gate", gate, (vals[(k/4)%4] != 0) && (k%4 != 3));
      chk("pat_step", step_idx, (k/4)%4);
      chk("pat_strobe", step_strobe, k%4 == 0);
      tick();
    end
    stop = 1; tick(); stop = 0;
    chk("loop_stopped", busy, 0);
`else
    for (int k = 0; k < 16; k++) begin
      chk("pat_period", period_out, vals[k/4]);
      chk("pat_gate", gate, (vals[k/4] != 0) && (k%4 != 3));
      chk("pat_step", step_idx, k/4);
      chk("pat_strobe", step_strobe, k%4 == 0);
      tick();
    end
    chk("end_done", done, 1);
    chk("end_period", period_out, 0);
    chk("end_busy", busy, 0);
    tick();
    chk("done_one_cycle", done, 0);
`endif

    // start and stop together while playing: stop wins
    start = 1; tick(); start = 0;
    repeat (5) tick();
    start = 1; stop = 1; tick(); start = 0; stop = 0;
    chk("startstop_busy", busy, 0);
    chk("startstop_period", period_out, 0);

    // tempo lowered below the running count mid-step
    tempo_div = 9; start = 1; tick(); start = 0;
    repeat (17) tick();
    chk("tempo_pre_step", step_idx, 1);
    tempo_div = 2;
    tick();
    chk("tempo_adv_step", step_idx, 2);
    chk("tempo_adv_strobe", step_strobe, 1);
    stop = 1; tick(); stop = 0;
    tempo_div = 3;

    // write to the sounding step only shows on its next visit
    start = 1; tick(); start = 0;
    repeat (4) tick();
    chk("wr_before", period_out, 25);
    wr_en = 1; wr_addr = 1; wr_data = 10'd50;
    tick();
    wr_en = 0;
    chk("wr_held", period_out, 25);
    repeat (2) tick();
    chk("wr_held_late", period_out, 25);
    start = 1; tick(); start = 0;
    repeat (4) tick();
    chk("wr_next_visit", period_out, 50);

    // asynchronous reset mid-play clears outputs without a clock edge
    repeat (3) tick();
    #3 rst_n = 0;
    #1;
    chk("async_period", period_out, 0);
    chk("async_gate", gate, 0);
    chk("async_busy", busy, 0);
    chk("async_step", step_idx, 0);
    chk("async_strobe", step_strobe, 0);
    m_reset();
    repeat (2) tick();
    rst_n = 1;
    tick();

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      start   = ($urandom_range(0, 39) == 0);
      stop    = ($urandom_range(0, 89) == 0);
      wr_en   = ($urandom_range(0, 5) == 0);
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
      if ($urandom_range(0, 99) == 0) tempo_div = 16'($urandom_range(0, 5));
      if ($urandom_range(0, 99) == 0) last_step = 3'($urandom_range(0, 7));
      tick();
    end
    start = 0; stop = 0; wr_en = 0;
    repeat (3) tick();
    chk_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
